// File: rtl/score_pkg.sv
// Shared encodings for the score latch slice: FSM states, game-state select codes
// and the channel-index width helper.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_PLAY = 2'b01;
    localparam logic [1:0] SEL_OVER = 2'b10;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_max_sel.sv
// Combinational argmax over CHANNELS packed score words; ties resolve to the lowest index.
module score_max_sel
    import score_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    localparam int CW      = idx_width(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] words,
    output logic [WIDTH-1:0]          max_val,
    output logic [CW-1:0]             max_idx
);

    logic [WIDTH-1:0] word_arr [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign word_arr[gi] = words[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Strict compare keeps the earlier channel on equal values.
    always_comb begin
        max_val = word_arr[0];
        max_idx = '0;
        for (int i = 1; i < CHANNELS; i++) begin
            if (word_arr[i] > max_val) begin
                max_val = word_arr[i];
                max_idx = CW'(i);
            end
        end
    end

endmodule

// File: rtl/score_latch_multi.sv
// Multi-player game-over score latch: freezes final scores once per game, tracks the
// running high score and drives an alternating display word while frozen.
module score_latch_multi
    import score_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 2,
    parameter int DISP_CYCLES = 100_000_000,
    localparam int CW         = idx_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                select,
    input  logic [CHANNELS*WIDTH-1:0] score_in,
    input  logic [CW-1:0]             disp_ch,
    input  logic                      clear_high,
    output logic [CHANNELS*WIDTH-1:0] latch_out,
    output logic [WIDTH-1:0]          high_score,
    output logic [CW-1:0]             high_ch,
    output logic                      new_record,
    output logic                      frozen,
    output logic [WIDTH-1:0]          display_out
);

    localparam int PW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    state_t                    state_reg, state_next;
    logic                      armed_reg;
    logic [CHANNELS*WIDTH-1:0] latch_reg;
    logic [WIDTH-1:0]          high_reg;
    logic [CW-1:0]             high_ch_reg;
    logic                      new_record_reg;
    logic [WIDTH-1:0]          display_reg, display_next;
    logic [PW-1:0]             phase_cnt_reg;
    logic                      phase_reg;

    logic [WIDTH-1:0] score_arr [CHANNELS];
    logic [WIDTH-1:0] latch_arr [CHANNELS];
    logic [CW-1:0]    disp_idx;
    logic [WIDTH-1:0] cap_max;
    logic [CW-1:0]    cap_idx;
    logic             play_entry;
    logic             cap_win;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign score_arr[gi] = score_in[gi*WIDTH +: WIDTH];
            assign latch_arr[gi] = latch_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    score_max_sel #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_max_sel (
        .words   (latch_reg),
        .max_val (cap_max),
        .max_idx (cap_idx)
    );

    assign disp_idx   = (int'(disp_ch) < CHANNELS) ? disp_ch : '0;
    assign play_entry = (state_next == ST_PLAY) && (state_reg != ST_PLAY);
    assign cap_win    = (state_reg == ST_CAPTURE) && (cap_max > high_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Reserved select 11 behaves like idle in every state.
    always_comb begin
        state_next   = state_reg;
        display_next = high_reg;
        case (state_reg)
            ST_IDLE: begin
                if (select == SEL_PLAY) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                display_next = score_arr[disp_idx];
                if (select == SEL_OVER && armed_reg) state_next = ST_CAPTURE;
                else if (select != SEL_PLAY && select != SEL_OVER) state_next = ST_IDLE;
            end
            ST_CAPTURE: begin
                display_next = score_arr[disp_idx];
                state_next   = ST_HOLD;
            end
            ST_HOLD: begin
                display_next = phase_reg ? high_reg : latch_arr[disp_idx];
                if (select == SEL_PLAY) state_next = ST_PLAY;
                else if (select != SEL_OVER) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_reg      <= 1'b0;
            latch_reg      <= '0;
            high_reg       <= '0;
            high_ch_reg    <= '0;
            new_record_reg <= 1'b0;
            display_reg    <= '0;
        end else begin
            display_reg <= display_next;
            if (play_entry) begin
                armed_reg      <= 1'b1;
                new_record_reg <= 1'b0;
            end
            if (state_next == ST_CAPTURE) begin
                latch_reg <= score_in;
                armed_reg <= 1'b0;
            end
            // A winning capture takes priority over a coincident clear.
            if (cap_win) begin
                high_reg       <= cap_max;
                high_ch_reg    <= cap_idx;
                new_record_reg <= 1'b1;
            end else if (clear_high) begin
                high_reg    <= '0;
                high_ch_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (state_reg != ST_HOLD) begin
            phase_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (phase_cnt_reg == PW'(DISP_CYCLES - 1)) begin
            phase_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
        end
    end

    assign latch_out   = latch_reg;
    assign high_score  = high_reg;
    assign high_ch     = high_ch_reg;
    assign new_record  = new_record_reg;
    assign frozen      = (state_reg == ST_HOLD);
    assign display_out = display_reg;

endmodule
